// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the program counter, selects the next fetch
// address, and holds the IF/ID pipeline register presented to decode.
module fetch_stage #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h0000_0000),
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_f,
  input  logic                  stall_d,
  input  logic                  flush_d,
  input  logic                  pcSrc_e,
  input  logic [DATA_WIDTH-1:0] pcTarget_e,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] pc_f,
  output logic [DATA_WIDTH-1:0] instr_d,
  output logic [DATA_WIDTH-1:0] pc_d,
  output logic [DATA_WIDTH-1:0] pcPlus4_d,
  output logic                  valid_d,
  output logic [31:0]           instrCount,
  output logic                  misaligned_f
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] pc_reg;
  logic [DATA_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] instr_reg;
  logic [DATA_WIDTH-1:0] pc_d_reg;
  logic [DATA_WIDTH-1:0] pc_plus4_d_reg;
  logic                  valid_reg;
  logic                  misaligned_reg;
  logic [31:0]           count_reg;
  logic                  flush_eff;
  logic                  load_d;
  logic                  target_misaligned;

  assign pc_plus4          = pc_reg + PC_STEP;
  // A taken redirect squashes whatever was fetched on the wrong path.
  assign flush_eff         = flush_d | pcSrc_e;
  assign load_d            = ~flush_eff & ~stall_d;
  assign target_misaligned = pcSrc_e & (pcTarget_e[1:0] != 2'b00);

  // The memory registers its address, so it must see the PC that is about
  // to be loaded rather than the current one.
  always_comb begin
    pc_next = pc_plus4;
    if (rst) begin
      pc_next = RESET_PC;
    end else if (pcSrc_e) begin
      pc_next = {pcTarget_e[DATA_WIDTH-1:2], 2'b00};
    end else if (stall_f) begin
      pc_next = pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    pc_reg <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_reg      <= NOP_INSTR;
      pc_d_reg       <= '0;
      pc_plus4_d_reg <= '0;
      valid_reg      <= 1'b0;
    end else if (flush_eff) begin
      instr_reg      <= NOP_INSTR;
      pc_d_reg       <= '0;
      pc_plus4_d_reg <= '0;
      valid_reg      <= 1'b0;
    end else if (!stall_d) begin
      instr_reg      <= imem_rdata;
      pc_d_reg       <= pc_reg;
      pc_plus4_d_reg <= pc_plus4;
      valid_reg      <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg      <= '0;
      misaligned_reg <= 1'b0;
    end else begin
      if (load_d) begin
        count_reg <= count_reg + 32'd1;
      end
      if (target_misaligned) begin
        misaligned_reg <= 1'b1;
      end
    end
  end

  assign imem_addr    = pc_next;
  assign pc_f         = pc_reg;
  assign instr_d      = instr_reg;
  assign pc_d         = pc_d_reg;
  assign pcPlus4_d    = pc_plus4_d_reg;
  assign valid_d      = valid_reg;
  assign instrCount   = count_reg;
  assign misaligned_f = misaligned_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then
// randomized hazard/redirect traffic checked each cycle against a fetch model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_f = 1'b0;
  logic        stall_d = 1'b0;
  logic        flush_d = 1'b0;
  logic        pcSrc_e = 1'b0;
  logic [31:0] pcTarget_e = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcPlus4_d;
  logic        valid_d;
  logic [31:0] instrCount;
  logic        misaligned_f;

  int n_vec = 0;
  int n_err = 0;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .pcSrc_e     (pcSrc_e),
    .pcTarget_e  (pcTarget_e),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .pc_f        (pc_f),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pcPlus4_d   (pcPlus4_d),
    .valid_d     (valid_d),
    .instrCount  (instrCount),
    .misaligned_f(misaligned_f)
  );

  always #5 clk = ~clk;

  // Word at byte address a holds 0x1000_0000 + word index.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) imem_rdata <= mem_f(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the PC that is being fetched, and what decode holds.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcd;
  logic        m_valid;
  logic [31:0] m_cnt;
  logic        m_mis;

  function automatic logic [31:0] m_fetch_addr();
    if (rst)          return 32'h0;
    else if (pcSrc_e) return pcTarget_e & 32'hFFFF_FFFC;
    else if (stall_f) return m_pc;
    else              return m_pc + 32'd4;
  endfunction

  always @(posedge clk) begin
    logic [31:0] fetched;
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h13; m_pcd = 32'h0; m_valid = 1'b0;
      m_cnt = 32'h0; m_mis = 1'b0;
    end else begin
      fetched = m_pc;
      m_pc = m_fetch_addr();
      if (pcSrc_e && pcTarget_e[1:0] != 2'b00) m_mis = 1'b1;
      if (flush_d || pcSrc_e) begin
        m_instr = 32'h13; m_pcd = 32'h0; m_valid = 1'b0;
      end else if (!stall_d) begin
        // The instruction arriving now is whatever lives at the current fetch PC.
        m_instr = mem_f(fetched); m_pcd = fetched; m_valid = 1'b1;
        m_cnt = m_cnt + 32'd1;
      end
    end
    #1;
    check("pc_f", pc_f, m_pc);
    check("imem_addr", imem_addr, m_fetch_addr());
    check("valid_d", {31'b0, valid_d}, {31'b0, m_valid});
    check("instr_d", instr_d, m_instr);
    check("pc_d", pc_d, m_pcd);
    check("pcPlus4_d", pcPlus4_d, m_valid ? m_pcd + 32'd4 : 32'h0);
    check("instrCount", instrCount, m_cnt);
    check("misaligned_f", {31'b0, misaligned_f}, {31'b0, m_mis});
    $display("cyc t=%0t rst=%0b sf=%0b sd=%0b fl=%0b br=%0b pc_f=%h instr_d=%h pc_d=%h v=%0b cnt=%0d mis=%0b",
             $time, rst, stall_f, stall_d, flush_d, pcSrc_e, pc_f, instr_d, pc_d, valid_d,
             instrCount, misaligned_f);
  end

  // Advance one edge; inputs may be changed right after the return.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    step(2);
    check("rst pc_f", pc_f, 32'h0);
    check("rst instr_d", instr_d, 32'h13);
    check("rst valid_d", {31'b0, valid_d}, 32'h0);
    check("rst instrCount", instrCount, 32'h0);

    rst = 1'b0;
    step();
    check("first instr_d", instr_d, 32'h1000_0000);
    check("first pc_d", pc_d, 32'h0);
    check("first pcPlus4_d", pcPlus4_d, 32'h4);
    check("first valid_d", {31'b0, valid_d}, 32'h1);
    step();
    check("run pc_f", pc_f, 32'h8);
    check("run instr_d", instr_d, 32'h1000_0001);

    stall_f = 1'b1; stall_d = 1'b1;
    step(3);
    check("stall pc_f", pc_f, 32'h8);
    check("stall imem_addr", imem_addr, 32'h8);
    check("stall pc_d", pc_d, 32'h4);
    check("stall instrCount", instrCount, 32'd2);
    stall_f = 1'b0; stall_d = 1'b0;
    step();
    check("unstall pc_f", pc_f, 32'hC);
    check("unstall instr_d", instr_d, 32'h1000_0002);
    step();
    check("pre-flush pc_f", pc_f, 32'h10);

    flush_d = 1'b1;
    step();
    flush_d = 1'b0;
    check("flush pc_f", pc_f, 32'h14);
    check("flush valid_d", {31'b0, valid_d}, 32'h0);
    check("flush pc_d", pc_d, 32'h0);
    check("flush instrCount", instrCount, 32'd4);
    step();

    stall_f = 1'b1; stall_d = 1'b1; pcSrc_e = 1'b1; pcTarget_e = 32'h40;
    step();
    stall_f = 1'b0; stall_d = 1'b0; pcSrc_e = 1'b0;
    check("redir pc_f", pc_f, 32'h40);
    check("redir instr_d", instr_d, 32'h13);
    step();
    check("redir+1 instr_d", instr_d, 32'h1000_0010);
    check("redir+1 pc_d", pc_d, 32'h40);

    pcSrc_e = 1'b1; pcTarget_e = 32'h0000_0102;
    step();
    pcSrc_e = 1'b0;
    check("misalign pc_f", pc_f, 32'h100);
    step(3);
    check("misalign sticky", {31'b0, misaligned_f}, 32'h1);

    pcSrc_e = 1'b1; pcTarget_e = 32'hFFFF_FFFC;
    step();
    pcSrc_e = 1'b0;
    step();
    check("wrap pc_f", pc_f, 32'h0);
    check("wrap instr_d", instr_d, 32'h4FFF_FFFF);
    check("wrap pcPlus4_d", pcPlus4_d, 32'h0);

    rst = 1'b1; pcSrc_e = 1'b1; pcTarget_e = 32'h200;
    step();
    rst = 1'b0; pcSrc_e = 1'b0;
    check("rst+br pc_f", pc_f, 32'h0);
    check("rst+br misaligned_f", {31'b0, misaligned_f}, 32'h0);
    check("rst+br instrCount", instrCount, 32'h0);

    for (int i = 0; i < 2000; i++) begin
      rst        = ($urandom_range(0, 63) == 0);
      stall_f    = ($urandom_range(0, 3) == 0);
      stall_d    = stall_f ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      flush_d    = ($urandom_range(0, 7) == 0);
      pcSrc_e    = ($urandom_range(0, 9) == 0);
      pcTarget_e = $urandom();
      if ($urandom_range(0, 3) != 0) pcTarget_e[1:0] = 2'b00;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register. It owns the program counter and drives the synchronous-read instruction memory address.
- It applies execute-stage redirects (branch, jal, jalr) and honours hazard-unit stall/flush.
- It presents instr_d, pc_d, pcPlus4_d and valid_d to decode, which feeds the ID/EX register.
- It also keeps a retired-fetch counter and a sticky misaligned-target flag.

Parameters:
- DATA_WIDTH, 32, width of PC, instruction and data words.
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) inserted into IF/ID on a bubble.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- stall_f  in  1  hold PC (hazard unit).
- stall_d  in  1  hold IF/ID register (hazard unit).
- flush_d  in  1  load bubble into IF/ID (hazard unit).
- pcSrc_e  in  1  redirect request from execute (taken branch/jump).
- pcTarget_e  in  DATA_WIDTH  redirect target from execute.
- imem_addr  out  DATA_WIDTH  instruction memory read address (combinational).
- imem_rdata  in  DATA_WIDTH  instruction memory data; 1-cycle latency from imem_addr.
- pc_f  out  DATA_WIDTH  current fetch PC.
- instr_d  out  DATA_WIDTH  IF/ID instruction.
- pc_d  out  DATA_WIDTH  IF/ID PC.
- pcPlus4_d  out  DATA_WIDTH  IF/ID PC+4.
- valid_d  out  1  IF/ID holds a real instruction (0 = bubble).
- instrCount  out  32  number of valid instructions loaded into IF/ID.
- misaligned_f  out  1  sticky: a redirect target had [1:0] != 0.

Behaviour:
Reset:
- Synchronous, active-high: when rst is high at posedge, pc_f=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pcPlus4_d=0, valid_d=0, instrCount=0, misaligned_f=0.

Next-PC select (combinational):
- Priority: rst > pcSrc_e > stall_f > increment.
- pc_next = RESET_PC if rst; else {pcTarget_e[31:2],2'b00} if pcSrc_e; else pc_f if stall_f; else pc_f+4.
- imem_addr = pc_next at all times, including during reset and stall.
- Because the memory is synchronous, imem_rdata in the cycle after an edge always corresponds to the new pc_f.
- On stall_f the same address is re-read, so imem_rdata stays stable without a holding register.

PC register:
- pc_f <= pc_next every posedge.
- Adds wrap modulo 2^DATA_WIDTH: 32'hFFFF_FFFC + 4 = 0.
- Redirect overrides stall_f in the same cycle.

IF/ID register (posedge):
- Effective flush = flush_d | pcSrc_e.
- Priority: rst > effective flush > stall_d > load.
- Flush: instr_d=NOP_INSTR, pc_d=0, pcPlus4_d=0, valid_d=0.
- stall_d with no flush: all IF/ID outputs hold.
- Load: instr_d=imem_rdata, pc_d=pc_f, pcPlus4_d=pc_f+4, valid_d=1.
- Latency: an instruction at address A is visible on instr_d 2 edges after A first appears on imem_addr (absent stalls/flushes).

instrCount:
- Increments by 1 on each posedge where the IF/ID register performs a load.
- Wraps modulo 2^32; holds otherwise.

misaligned_f:
- Set on posedge when pcSrc_e=1 and pcTarget_e[1:0]!=0, not in reset.
- Stays set until rst. The PC uses the target with bits [1:0] cleared.

Other boundary rules:
- stall_f without stall_d is legal: the IF/ID register reloads the same pc_f/instruction each cycle.
- Reset asserted mid-stall or mid-redirect wins unconditionally. The first fetch after reset release is RESET_PC, valid on instr_d one edge after release.

Test Plan:
- Reset then free-run, RESET_PC=0, mem[i]=32'h1000_0000+i → imem_addr 0,4,8,…; instr_d=32'h1000_0000 with pc_d=0, pcPlus4_d=4, valid_d=1 at first edge after rst release; subsequent instructions 1/cycle; instrCount increments each cycle.
- stall_f=stall_d=1 for 3 cycles at pc_f=8 → pc_f stays 8, imem_addr=8, instr_d/pc_d=4 held, instrCount frozen; after release pc_f=12 next edge, no instruction lost or duplicated.
- pcSrc_e=1, pcTarget_e=32'h40 while stall_f=stall_d=1 → pc_f=32'h40 next edge, valid_d=0, instr_d=32'h13; following edge instr_d=mem[0x40], pc_d=32'h40.
- flush_d=1 alone at pc_f=16 → IF/ID bubble (valid_d=0, pc_d=0), pc_f=20; instrCount not incremented that edge.
- pcSrc_e=1, pcTarget_e=32'h0000_0102 → pc_f=32'h100, misaligned_f=1 and stays 1 through later fetches until rst.
- PC wrap: force pc_f to 32'hFFFF_FFFC via redirect, free-run → next pc_f=0; rst asserted during a pcSrc_e cycle → pc_f=RESET_PC, all outputs at reset values.
